// File: rtl/hart_mailbox_reg.sv
// Inter-hart mailbox on a zero-wait register bus: one 32-bit FIFO per hart,
// pushed by any hart through DATA writes, popped by its owner through DATA
// reads, with a per-hart level interrupt while messages are pending.

package hart_mailbox_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module hart_mailbox_reg #(
  parameter int unsigned NHARTS = 3,
  parameter int unsigned DEPTH  = 4,
  parameter type reg_req_t = hart_mailbox_pkg::reg_req_t,
  parameter type reg_rsp_t = hart_mailbox_pkg::reg_rsp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  reg_req_t          reg_req_i,
  output reg_rsp_t          reg_rsp_o,
  output logic [NHARTS-1:0] irq_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  logic [31:0]       mem_q    [NHARTS][DEPTH];
  logic [PW-1:0]     wr_ptr_q [NHARTS];
  logic [PW-1:0]     rd_ptr_q [NHARTS];
  logic [CW-1:0]     count_q  [NHARTS];
  logic [NHARTS-1:0] irq_en_q;
  logic [NHARTS-1:0] empty;
  logic [NHARTS-1:0] full;

  logic [3:0]    hart;
  logic [1:0]    sel;
  logic          hart_ok;
  logic [HW-1:0] hidx;
  logic          push;
  logic          pop;
  logic          ctrl_we;
  reg_rsp_t      rsp;
  logic          unused_addr;

  assign hart        = reg_req_i.addr[7:4];
  assign sel         = reg_req_i.addr[3:2];
  assign hart_ok     = {28'b0, hart} < NHARTS;
  // Clamp the index so out-of-range harts never address past the arrays.
  assign hidx        = hart_ok ? hart[HW-1:0] : '0;
  assign unused_addr = ^{reg_req_i.addr[31:8], reg_req_i.addr[1:0]};

  // Per-hart FIFO flags and the level interrupt, from registered state only.
  always_comb begin
    for (int h = 0; h < NHARTS; h++) begin
      empty[h] = (count_q[h] == '0);
      full[h]  = (count_q[h] == CW'(DEPTH));
    end
    irq_o = irq_en_q & ~empty;
  end

  // Address decode, response data/error and the single per-cycle FIFO/CTRL op.
  always_comb begin
    rsp       = '0;
    push      = 1'b0;
    pop       = 1'b0;
    ctrl_we   = 1'b0;
    rsp.ready = reg_req_i.valid;
    if (reg_req_i.valid) begin
      if (!hart_ok) begin
        rsp.error = 1'b1;
      end else begin
        unique case (sel)
          2'd0: begin
            if (reg_req_i.write) begin
              if (reg_req_i.wstrb != 4'hF || full[hidx]) rsp.error = 1'b1;
              else                                         push      = 1'b1;
            end else if (empty[hidx]) begin
              rsp.error = 1'b1;
            end else begin
              pop       = 1'b1;
              rsp.rdata = mem_q[hidx][rd_ptr_q[hidx]];
            end
          end
          2'd1: begin
            if (reg_req_i.write) begin
              rsp.error = 1'b1;
            end else begin
              rsp.rdata[15:0] = 16'(count_q[hidx]);
              rsp.rdata[16]   = empty[hidx];
              rsp.rdata[17]   = full[hidx];
            end
          end
          2'd2: begin
            if (reg_req_i.write) ctrl_we      = reg_req_i.wstrb[0];
            else                 rsp.rdata[0] = irq_en_q[hidx];
          end
          default: rsp.error = 1'b1;
        endcase
      end
    end
  end

  assign reg_rsp_o = rsp;

  // Pointer, count and irq-enable state; flush rewinds one FIFO to empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int h = 0; h < NHARTS; h++) begin
        wr_ptr_q[h] <= '0;
        rd_ptr_q[h] <= '0;
        count_q[h]  <= '0;
      end
      irq_en_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q[hidx] <= wr_ptr_q[hidx] + PW'(1);
        count_q[hidx]  <= count_q[hidx] + CW'(1);
      end
      if (pop) begin
        rd_ptr_q[hidx] <= rd_ptr_q[hidx] + PW'(1);
        count_q[hidx]  <= count_q[hidx] - CW'(1);
      end
      if (ctrl_we) begin
        irq_en_q[hidx] <= reg_req_i.wdata[0];
        if (reg_req_i.wdata[1]) begin
          wr_ptr_q[hidx] <= '0;
          rd_ptr_q[hidx] <= '0;
          count_q[hidx]  <= '0;
        end
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[hidx][wr_ptr_q[hidx]] <= reg_req_i.wdata;
  end

endmodule
